// File: rtl/avl_pkg.sv
// Shared types for the Avalon-MM command master.
// Command bundle layout, bus widths and FSM state encoding.
package avl_pkg;

    localparam int AVL_ADDR_W = 12;
    localparam int AVL_DATA_W = 32;
    localparam int AVL_BE_W   = 4;

    typedef struct packed {
        logic                  write;
        logic [AVL_ADDR_W-1:0] addr;
        logic [AVL_BE_W-1:0]   byte_en;
        logic [AVL_DATA_W-1:0] data;
    } avl_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_RD_WAIT,
        ST_GAP
    } avl_master_state_t;

endpackage

// File: rtl/avl_cmd_fifo.sv
// Synchronous command FIFO of avl_cmd_t entries.
// Depth is a power of two so pointers wrap by natural overflow.
module avl_cmd_fifo
    import avl_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic     CLK,
    input  logic     RESET,
    input  logic     i_push,
    input  avl_cmd_t i_data,
    input  logic     i_pop,
    output avl_cmd_t o_data,
    output logic     o_full,
    output logic     o_empty
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(FIFO_DEPTH);

    avl_cmd_t      r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CNT_FULL);
    assign o_empty = (r_count == '0);

    // Storage array: written at the tail on push, no reset needed.
    always_ff @(posedge CLK) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy tracking; push+pop leaves count unchanged.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            unique case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/avl_cmd_master.sv
// Queued command master driving an Avalon-MM register slave.
// AVL_CMD_MASTER_GAP_EN inserts an idle GAP cycle after every bus cycle.
module avl_cmd_master
    import avl_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_WRITE,
    input  logic [AVL_ADDR_W-1:0] REQ_ADDR,
    input  logic [AVL_DATA_W-1:0] REQ_DATA,
    input  logic [AVL_BE_W-1:0]   REQ_BYTE_EN,
    output logic                  RSP_VALID,
    output logic [AVL_DATA_W-1:0] RSP_DATA,
    output logic                  AVL_CS,
    output logic                  AVL_READ,
    output logic                  AVL_WRITE,
    output logic [AVL_ADDR_W-1:0] AVL_ADDR,
    output logic [AVL_BE_W-1:0]   AVL_BYTE_EN,
    output logic [AVL_DATA_W-1:0] AVL_WRITEDATA,
    input  logic [AVL_DATA_W-1:0] AVL_READDATA,
    output logic                  BUSY
);

    localparam logic [1:0] LAT_LOAD = 2'(READ_LATENCY - 1);

    avl_master_state_t     r_state, w_state_nxt;
    logic [1:0]            r_lat_cnt, w_lat_nxt;
    logic                  r_cs, w_cs_nxt;
    logic                  r_rd, w_rd_nxt;
    logic                  r_wr, w_wr_nxt;
    logic [AVL_ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [AVL_BE_W-1:0]   r_be, w_be_nxt;
    logic [AVL_DATA_W-1:0] r_wdata, w_wdata_nxt;
    logic                  r_rsp_vld, w_rsp_vld_nxt;
    logic [AVL_DATA_W-1:0] r_rsp_data, w_rsp_data_nxt;
    logic                  r_rdy_en;

    logic     w_push, w_pop, w_issue;
    logic     w_full, w_empty;
    avl_cmd_t w_req_cmd, w_head;

    assign w_req_cmd = '{write: REQ_WRITE, addr: REQ_ADDR,
                         byte_en: REQ_BYTE_EN, data: REQ_DATA};
    assign REQ_READY = r_rdy_en & ~w_full;
    assign w_push    = REQ_VALID & REQ_READY;

    avl_cmd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RESET   (RESET),
        .i_push  (w_push),
        .i_data  (w_req_cmd),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Next state and next bus/response register values.
    always_comb begin
        w_state_nxt    = r_state;
        w_lat_nxt      = r_lat_cnt;
        w_cs_nxt       = 1'b0;
        w_rd_nxt       = 1'b0;
        w_wr_nxt       = 1'b0;
        w_addr_nxt     = r_addr;
        w_be_nxt       = r_be;
        w_wdata_nxt    = r_wdata;
        w_rsp_vld_nxt  = 1'b0;
        w_rsp_data_nxt = r_rsp_data;
        w_issue        = 1'b0;
        w_pop          = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_issue = 1'b1;
            end
            ST_WRITE: begin
`ifdef AVL_CMD_MASTER_GAP_EN
                w_state_nxt = ST_GAP;
`else
                w_state_nxt = ST_IDLE;
                w_issue     = 1'b1;
`endif
            end
            ST_READ: begin
                w_state_nxt = ST_RD_WAIT;
                w_lat_nxt   = LAT_LOAD;
            end
            ST_RD_WAIT: begin
                if (r_lat_cnt == 2'd0) begin
                    w_rsp_vld_nxt  = 1'b1;
                    w_rsp_data_nxt = AVL_READDATA;
`ifdef AVL_CMD_MASTER_GAP_EN
                    w_state_nxt    = ST_GAP;
`else
                    w_state_nxt    = ST_IDLE;
                    w_issue        = 1'b1;
`endif
                end else begin
                    w_lat_nxt = r_lat_cnt - 2'd1;
                end
            end
            ST_GAP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (w_issue && !w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = w_head.write ? ST_WRITE : ST_READ;
            w_cs_nxt    = 1'b1;
            w_wr_nxt    = w_head.write;
            w_rd_nxt    = ~w_head.write;
            w_addr_nxt  = w_head.addr;
            w_be_nxt    = w_head.byte_en;
            w_wdata_nxt = w_head.data;
        end
    end

    // State, registered bus outputs and response registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state    <= ST_IDLE;
            r_lat_cnt  <= '0;
            r_cs       <= 1'b0;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
            r_addr     <= '0;
            r_be       <= '0;
            r_wdata    <= '0;
            r_rsp_vld  <= 1'b0;
            r_rsp_data <= '0;
            r_rdy_en   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lat_cnt  <= w_lat_nxt;
            r_cs       <= w_cs_nxt;
            r_rd       <= w_rd_nxt;
            r_wr       <= w_wr_nxt;
            r_addr     <= w_addr_nxt;
            r_be       <= w_be_nxt;
            r_wdata    <= w_wdata_nxt;
            r_rsp_vld  <= w_rsp_vld_nxt;
            r_rsp_data <= w_rsp_data_nxt;
            r_rdy_en   <= 1'b1;
        end
    end

    assign AVL_CS        = r_cs;
    assign AVL_READ      = r_rd;
    assign AVL_WRITE     = r_wr;
    assign AVL_ADDR      = r_addr;
    assign AVL_BYTE_EN   = r_be;
    assign AVL_WRITEDATA = r_wdata;
    assign RSP_VALID     = r_rsp_vld;
    assign RSP_DATA      = r_rsp_data;
    assign BUSY          = ~w_empty | (r_state != ST_IDLE);

endmodule

// File: doc/avl_cmd_master.md
AVL_CMD_MASTER -- requirements
Module: avl_cmd_master

Interface
REQ-001 Parameters: FIFO_DEPTH, 4, command FIFO entries (power of two, 2..16); READ_LATENCY, 1, cycles from read issue to AVL_READDATA valid (1..4).
REQ-002 CLK  in  1  sole clock; all logic on rising edge.
REQ-003 RESET  in  1  asynchronous, active-low reset; asserts immediately, releases synchronously to CLK.
REQ-004 REQ_VALID  in  1  command offered; REQ_READY  out  1  FIFO can accept; transfer when both high on a CLK edge.
REQ-005 REQ_WRITE  in  1  1=write, 0=read; REQ_ADDR  in  12  word address; REQ_DATA  in  32  write data; REQ_BYTE_EN  in  4  byte lanes.
REQ-006 RSP_VALID  out  1  one-cycle pulse, read data valid; RSP_DATA  out  32  captured read data.
REQ-007 AVL_CS, AVL_READ, AVL_WRITE  out  1 each; AVL_ADDR  out  12; AVL_BYTE_EN  out  4; AVL_WRITEDATA  out  32; AVL_READDATA  in  32 -- Avalon-MM master port to the VGA register slave.
REQ-008 BUSY  out  1  high when FIFO non-empty or FSM not IDLE.

Function
REQ-009 Command FIFO FIFO_DEPTH x 49 bits {write, addr, byte_en, data}; REQ_READY = not full, from registered count only.
REQ-010 Push and pop in the same cycle keep count unchanged; push while full never occurs (READY low); pop while empty never occurs.
REQ-011 Pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
REQ-012 FSM states IDLE, WRITE, READ, RD_WAIT, GAP.
REQ-013 IDLE: if FIFO non-empty, pop head and go WRITE or READ next cycle; else stay.
REQ-014 Earliest bus cycle is the second edge after the accepting edge (FIFO write, then pop).
REQ-015 WRITE: exactly one cycle with AVL_CS=1, AVL_WRITE=1, AVL_READ=0, addr/byte_en/data from popped entry; then GAP.
REQ-016 READ: one cycle with AVL_CS=1, AVL_READ=1, AVL_WRITE=0; then RD_WAIT.
REQ-017 RD_WAIT: down-counter loaded with READ_LATENCY-1 at READ; when zero, capture AVL_READDATA into RSP_DATA, pulse RSP_VALID next cycle, go GAP.
REQ-018 GAP: one cycle, all strobes low, then IDLE; CS never asserted in consecutive cycles.
REQ-019 Outside WRITE/READ: AVL_CS, AVL_READ, AVL_WRITE = 0; AVL_ADDR/BYTE_EN/WRITEDATA hold last value.
REQ-020 All AVL_* outputs registered; no combinational path from REQ_* to AVL_*.
REQ-021 RSP_DATA holds until next read completes.

Reset
REQ-022 RESET low: FSM=IDLE, FIFO empty, pointers/count 0, REQ_READY=0 while asserted and 1 the first cycle after release.
REQ-023 Reset values: AVL_CS/READ/WRITE=0, AVL_ADDR=0, AVL_BYTE_EN=0, AVL_WRITEDATA=0, RSP_VALID=0, RSP_DATA=0, BUSY=0.
REQ-024 Reset mid-transaction aborts it: strobes drop asynchronously, queued commands discarded, no RSP_VALID.

Configuration
REQ-025 Macro AVL_CMD_MASTER_GAP_EN: defined -> GAP state present per REQ-018; undefined -> WRITE/RD_WAIT go directly to IDLE, allowing back-to-back bus cycles (one per clock when FIFO non-empty).

Structure
REQ-026 Shared package avl_pkg: avl_cmd_t packed struct {write, addr[11:0], byte_en[3:0], data[31:0]}, AVL_ADDR_W=12, AVL_DATA_W=32, state enum avl_master_state_t.
REQ-027 One sub-module: avl_cmd_fifo (synchronous FIFO of avl_cmd_t, FIFO_DEPTH parameter); FSM and bus registers in avl_cmd_master.

Verification
REQ-028 Reset: RESET low 5 cycles with REQ_VALID=1 -> no AVL_CS, REQ_READY=0, all outputs at reset values.
REQ-029 Single write addr 12'h800, data 32'h00141400, byte_en 4'hF -> exactly one AVL_CS+AVL_WRITE cycle with those values, 2 edges after accept; BUSY clears after GAP.
REQ-030 Read addr 12'h017, slave returns 32'h0000_2CC0 at READ_LATENCY=1 -> RSP_VALID single pulse, RSP_DATA=32'h0000_2CC0.
REQ-031 Burst of 6 writes (12'h002..12'h007) held valid -> REQ_READY low after 4 queued, all 6 issued in order, CS separated by >=1 idle cycle (GAP_EN) or contiguous (undefined).
REQ-032 Simultaneous push/pop at count 3 -> count stays 3, no lost or duplicated command across pointer wrap.
REQ-033 RESET asserted during RD_WAIT with 2 commands queued -> strobes low at once, no RSP_VALID, neither queued command issued after release.
